// File: rtl/rv64b_ise_pkg.sv
// rtl/rv64b_ise_pkg.sv - shared encodings, FSM states and rotate helper for the bitmanip issue block
package rv64b_ise_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [2:0] F3_RORI    = 3'b101;
  localparam logic [2:0] F3_ORN     = 3'b110;
  localparam logic [2:0] F3_ANDN    = 3'b111;
  localparam logic [5:0] F6_RORI    = 6'b011000;
  localparam logic [6:0] F7_ZBB     = 7'b0100000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROT  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Duplicating the word makes the rotate modulo 64 with no special case for zero.
  function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

endpackage

// File: rtl/rv64b_ise_dec.sv
// rtl/rv64b_ise_dec.sv - combinational decode of RORI/ORN/ANDN into one-hot ops plus shamt and rd index
module rv64b_ise_dec
  import rv64b_ise_pkg::*;
(
  input  logic [31:0] instr,
  output logic        op_rori,
  output logic        op_orn,
  output logic        op_andn,
  output logic        illegal,
  output logic [5:0]  shamt,
  output logic [4:0]  rd_idx
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [5:0] funct6;
  logic       unused_rs1;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign funct6 = instr[31:26];
  assign unused_rs1 = ^instr[19:15];

  assign op_rori = (opcode == OPC_OP_IMM) && (funct3 == F3_RORI) && (funct6 == F6_RORI);
  assign op_orn  = (opcode == OPC_OP) && (funct3 == F3_ORN) && (funct7 == F7_ZBB);
  assign op_andn = (opcode == OPC_OP) && (funct3 == F3_ANDN) && (funct7 == F7_ZBB);
  assign illegal = !(op_rori || op_orn || op_andn);

  assign shamt  = instr[25:20];
  assign rd_idx = instr[11:7];

endmodule

// File: rtl/rv64b_ise_issue.sv
// rtl/rv64b_ise_issue.sv - single-issue RORI/ORN/ANDN unit with two-stage rotate and held result
module rv64b_ise_issue
  import rv64b_ise_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [63:0] in_rs1,
  input  logic [63:0] in_rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rd,
  output logic [4:0]  out_rd_idx,
  output logic        out_illegal
);

  logic        op_rori;
  logic        op_orn;
  logic        op_andn;
  logic        illegal;
  logic [5:0]  shamt;
  logic [4:0]  rd_idx;

  state_t      state;
  logic [63:0] rot_val;
  logic [2:0]  rot_hi;
  logic        accept;
  logic [63:0] logic_res;
  logic [63:0] stage1;
  logic [63:0] stage2;

  rv64b_ise_dec u_dec (
    .instr   (in_instr),
    .op_rori (op_rori),
    .op_orn  (op_orn),
    .op_andn (op_andn),
    .illegal (illegal),
    .shamt   (shamt),
    .rd_idx  (rd_idx)
  );

  assign in_ready = (state == S_IDLE) && !g_rst;
  assign accept   = in_valid && in_ready;

  // Rotate split: fine bit step on accept, byte step in ROT.
  always_comb begin
    logic_res = '0;
    if (op_orn) begin
      logic_res = in_rs1 | ~in_rs2;
    end else if (op_andn) begin
      logic_res = in_rs1 & ~in_rs2;
    end
    stage1 = ror64(in_rs1, {3'b000, shamt[2:0]});
    stage2 = ror64(rot_val, {rot_hi, 3'b000});
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state       <= S_IDLE;
      rot_val     <= '0;
      rot_hi      <= '0;
      out_valid   <= 1'b0;
      out_rd      <= '0;
      out_rd_idx  <= '0;
      out_illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            out_rd_idx <= rd_idx;
            if (op_rori) begin
              rot_val     <= stage1;
              rot_hi      <= shamt[5:3];
              out_illegal <= 1'b0;
              state       <= S_ROT;
            end else begin
              out_rd      <= logic_res;
              out_illegal <= illegal;
              out_valid   <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_ROT: begin
          out_rd    <= stage2;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
